eco_equiv_sequencer: RTL and testbench

- Exhaustive stimulus sequencer and checker for the small 2x4-bit-input, 4-bit-output gate-level ECO netlists.
- Drives every a/b input combination into a pre-ECO and a post-ECO instance of the same netlist, and compares their y outputs after a programmable settle time.
- Reports the mismatch count, the first mismatching vector and a pass flag.
- Sits in the ECO test harness, one level above the two combinational netlist instances.

---
 rtl/eco_equiv_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_eco_equiv_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/eco_equiv_sequencer.sv
// eco_equiv_sequencer
//   Exhaustive stimulus sequencer / checker for small 2xW-bit-input, YW-bit-output
//   gate-level ECO netlists. Walks idx = {b,a} from 0 to 2^(2W)-1, drives both the
//   pre-ECO and post-ECO instances, waits SETTLE cycles, then compares masked y.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               pulse, begins a run (accepted in IDLE or DONE only)
//   abort               level, terminates a run (priority over all but reset)
//   stop_first          latched on start: end the run at the first mismatch
//   y_mask              latched on start: 1 = compare that y bit
//   a_out, b_out        registered stimulus to both instances
//   y_old, y_new        outputs of the pre-ECO / post-ECO instances
//   busy, done, pass    run status (pass valid while done=1)
//   mism_cnt            saturating count of mismatching vectors
//   first_vec           {b,a} of the first mismatch, first_valid flags it
module eco_equiv_sequencer #(
   parameter int W      = 4,
   parameter int YW     = 4,
   parameter int SETTLE = 1,
   parameter int CNT_W  = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               stop_first,
   input  logic [YW-1:0]      y_mask,
   output logic [W-1:0]       a_out,
   output logic [W-1:0]       b_out,
   input  logic [YW-1:0]      y_old,
   input  logic [YW-1:0]      y_new,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   mism_cnt,
   output logic [2*W-1:0]     first_vec,
   output logic               first_valid
);

   localparam int IW   = 2 * W;
   localparam int WC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WC_W-1:0] WAIT_LAST = (SETTLE > 0) ? WC_W'(SETTLE - 1) : '0;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_APPLY = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    fvec_q, fvec_d;
   logic             fvalid_q, fvalid_d;
   logic             stop_q, stop_d;
   logic [YW-1:0]    mask_q, mask_d;
   logic [WC_W-1:0]  wcnt_q, wcnt_d;
   logic             mismatch;

   // Only meaningful in CHECK; y is ignored in every other state.
   assign mismatch = |((y_old ^ y_new) & mask_q);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      cnt_d    = cnt_q;
      fvec_d   = fvec_q;
      fvalid_d = fvalid_q;
      stop_d   = stop_q;
      mask_d   = mask_q;
      wcnt_d   = wcnt_q;

      if (abort) begin
         // Partial results (count, first vector) and stimulus are kept for debug.
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  cnt_d    = '0;
                  fvec_d   = '0;
                  fvalid_d = 1'b0;
                  done_d   = 1'b0;
                  pass_d   = 1'b0;
                  stop_d   = stop_first;
                  mask_d   = y_mask;
                  idx_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = S_APPLY;
               end
            end
            S_APPLY: begin
               a_d    = idx_q[W-1:0];
               b_d    = idx_q[IW-1:W];
               wcnt_d = '0;
               state_d = (SETTLE == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
               if (wcnt_q == WAIT_LAST) begin
                  state_d = S_CHECK;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
            S_CHECK: begin
               if (mismatch) begin
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
                  if (!fvalid_q) begin
                     fvec_d   = idx_q;
                     fvalid_d = 1'b1;
                  end
               end
               if ((idx_q == '1) || (mismatch && stop_q)) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (cnt_d == '0);
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_APPLY;
               end
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         cnt_q    <= '0;
         fvec_q   <= '0;
         fvalid_q <= 1'b0;
         stop_q   <= 1'b0;
         mask_q   <= '0;
         wcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         cnt_q    <= cnt_d;
         fvec_q   <= fvec_d;
         fvalid_q <= fvalid_d;
         stop_q   <= stop_d;
         mask_q   <= mask_d;
         wcnt_q   <= wcnt_d;
      end
   end

   assign a_out       = a_q;
   assign b_out       = b_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign mism_cnt    = cnt_q;
   assign first_vec   = fvec_q;
   assign first_valid = fvalid_q;

endmodule

// File: tb/tb_eco_equiv_sequencer.sv
// Directed bench for eco_equiv_sequencer. y_old is modelled as a_out+b_out; y_new
// is derived from it according to the fault mode. A second instance with CNT_W=4
// always sees inverted y to exercise counter saturation.
module tb_eco_equiv_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic       stop_first;
   logic [3:0] y_mask;
   logic [3:0] a_out, b_out;
   logic [3:0] y_old, y_new;
   logic       busy, done, pass;
   logic [8:0] mism_cnt;
   logic [7:0] first_vec;
   logic       first_valid;

   logic [3:0] s_a, s_b, s_ynew;
   logic       s_busy, s_done, s_pass;
   logic [3:0] s_cnt;
   logic [7:0] s_fvec;
   logic       s_fvalid;

   // 0: identical, 1: y_new[0] flipped at a=3,b=5, 2: y_new = ~y_old
   int unsigned mode;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign y_old = a_out + b_out;
   always_comb begin
      y_new = y_old;
      if (mode == 1 && a_out == 4'd3 && b_out == 4'd5) y_new = y_old ^ 4'b0001;
      else if (mode == 2) y_new = ~y_old;
   end
   assign s_ynew = ~(s_a + s_b);

   eco_equiv_sequencer #(.W(4), .YW(4), .SETTLE(1), .CNT_W(9)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .stop_first(stop_first), .y_mask(y_mask),
      .a_out(a_out), .b_out(b_out), .y_old(y_old), .y_new(y_new),
      .busy(busy), .done(done), .pass(pass), .mism_cnt(mism_cnt),
      .first_vec(first_vec), .first_valid(first_valid)
   );

   eco_equiv_sequencer #(.W(4), .YW(4), .SETTLE(1), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .stop_first(stop_first), .y_mask(y_mask),
      .a_out(s_a), .b_out(s_b), .y_old(s_a + s_b), .y_new(s_ynew),
      .busy(s_busy), .done(s_done), .pass(s_pass), .mism_cnt(s_cnt),
      .first_vec(s_fvec), .first_valid(s_fvalid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_vec(input string tag, input logic [7:0] v);
      bit seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if ({b_out, a_out} == v) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ab"},     {24'd0, b_out, a_out}, 32'd0);
      chk({tag, "_busy"},   32'(busy), 32'd0);
      chk({tag, "_done"},   32'(done), 32'd0);
      chk({tag, "_pass"},   32'(pass), 32'd0);
      chk({tag, "_cnt"},    32'(mism_cnt), 32'd0);
      chk({tag, "_fvec"},   32'(first_vec), 32'd0);
      chk({tag, "_fvalid"}, 32'(first_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; stop_first = 1'b0;
      y_mask = 4'hF; mode = 0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Full clean run: exact 768-cycle length
      pulse_start();
      chk("t1_busy_start", 32'(busy), 32'd1);
      repeat (767) @(posedge clk);
      #1;
      chk("t1_busy_767", 32'(busy), 32'd1);
      chk("t1_done_767", 32'(done), 32'd0);
      chk("sat_hold_mid", 32'(s_cnt), 32'd15);
      @(posedge clk);
      #1;
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_pass", 32'(pass), 32'd1);
      chk("t1_cnt", 32'(mism_cnt), 32'd0);
      chk("t1_fvalid", 32'(first_valid), 32'd0);
      chk("t1_ab", {24'd0, b_out, a_out}, 32'hFF);
      chk("sat_cnt", 32'(s_cnt), 32'd15);
      chk("sat_pass", 32'(s_pass), 32'd0);
      chk("sat_done", 32'(s_done), 32'd1);
      chk("sat_fvec", 32'(s_fvec), 32'h00);
      chk("sat_fvalid", 32'(s_fvalid), 32'd1);

      // Single fault at a=3,b=5
      mode = 1;
      pulse_start();
      chk("t2_done_clr", 32'(done), 32'd0);
      wait_done("t2_finish");
      chk("t2_cnt", 32'(mism_cnt), 32'd1);
      chk("t2_fvec", 32'(first_vec), 32'h53);
      chk("t2_fvalid", 32'(first_valid), 32'd1);
      chk("t2_pass", 32'(pass), 32'd0);

      // Same fault masked out
      y_mask = 4'b1110;
      pulse_start();
      wait_done("t3_finish");
      chk("t3_pass", 32'(pass), 32'd1);
      chk("t3_cnt", 32'(mism_cnt), 32'd0);
      chk("t3_fvalid", 32'(first_valid), 32'd0);
      y_mask = 4'hF;

      // Stop at first mismatch: vector 0, done 3 cycles after start
      mode = 2; stop_first = 1'b1;
      pulse_start();
      stop_first = 1'b0;
      @(posedge clk); @(posedge clk);
      #1;
      chk("t4_done_early", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_cnt", 32'(mism_cnt), 32'd1);
      chk("t4_fvec", 32'(first_vec), 32'h00);
      chk("t4_pass", 32'(pass), 32'd0);
      chk("t4_ab", {24'd0, b_out, a_out}, 32'h00);

      // Abort at idx 0x20 with a simultaneous start
      pulse_start();
      wait_vec("t5_reach20", 8'h20);
      abort = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0; start = 1'b0;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_pass", 32'(pass), 32'd0);
      chk("t5_cnt", 32'(mism_cnt), 32'd32);
      chk("t5_fvalid", 32'(first_valid), 32'd1);
      chk("t5_ab", {24'd0, b_out, a_out}, 32'h20);
      @(posedge clk);
      #1;
      chk("t5_idle", 32'(busy), 32'd0);

      // Restart clears partial results and completes
      mode = 0;
      pulse_start();
      chk("t6_cnt_clr", 32'(mism_cnt), 32'd0);
      wait_done("t6_finish");
      chk("t6_pass", 32'(pass), 32'd1);
      chk("t6_fvalid", 32'(first_valid), 32'd0);
      chk("t6_fvec", 32'(first_vec), 32'd0);

      // Asynchronous reset mid-run at idx 0x80
      mode = 2;
      pulse_start();
      wait_vec("t7_reach80", 8'h80);
      chk("t7_cnt_pre", 32'(mism_cnt), 32'd128);
      rst_n = 1'b0;
      #1;
      chk_all_zero("t7_async");
      @(negedge clk);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
